// File: rtl/cr16_psr.sv
// cr16_psr: CR16 processor status register with per-opcode flag mask,
// one-deep interrupt shadow and Bcond/Jcond/Scond condition evaluation.
module cr16_psr #(
    parameter logic [4:0] RESET_PSR = 5'b00000
) (
    input  logic       I_CLK,
    input  logic       I_RESET,
    input  logic       I_ENABLE,
    input  logic [3:0] I_OPCODE,
    input  logic [4:0] I_STATUS,
    input  logic       I_WRITE,
    input  logic [4:0] I_WRITE_DATA,
    input  logic       I_SAVE,
    input  logic       I_RESTORE,
    input  logic [3:0] I_COND,
    output logic [4:0] O_PSR,
    output logic       O_COND_TRUE,
    output logic       O_SHADOW_VALID,
    output logic       O_ERROR
);
    logic [4:0] psr, shadow, masked, psr_next;
    logic       shadow_valid, error, restore_ok, cond_true;

    assign restore_ok = I_RESTORE && shadow_valid;

    // Arithmetic ops load every flag; logic/shift ops only touch Z.
    always_comb begin
        masked = I_OPCODE <= 4'd5  ? I_STATUS :
                 I_OPCODE <= 4'd13 ? {psr[4], I_STATUS[3], psr[2:0]} : psr;
        psr_next = restore_ok ? shadow :
                   I_WRITE    ? I_WRITE_DATA :
                   I_ENABLE   ? masked : psr;
    end

    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) begin
            psr          <= RESET_PSR;
            shadow       <= RESET_PSR;
            shadow_valid <= 1'b0;
            error        <= 1'b0;
        end else begin
            psr          <= psr_next;
            shadow       <= I_SAVE ? psr : shadow;
            shadow_valid <= I_SAVE ? 1'b1 : restore_ok ? 1'b0 : shadow_valid;
            error        <= I_RESTORE && !shadow_valid;
        end
    end

    // Flag layout: {N, Z, F, L, C}
    always_comb begin
        cond_true = 1'b0;
        case (I_COND)
            4'd0:    cond_true = psr[3];
            4'd1:    cond_true = !psr[3];
            4'd2:    cond_true = psr[0];
            4'd3:    cond_true = !psr[0];
            4'd4:    cond_true = psr[1];
            4'd5:    cond_true = !psr[1];
            4'd6:    cond_true = psr[4];
            4'd7:    cond_true = !psr[4];
            4'd8:    cond_true = psr[2];
            4'd9:    cond_true = !psr[2];
            4'd10:   cond_true = !psr[1] && !psr[3];
            4'd11:   cond_true = psr[1] || psr[3];
            4'd12:   cond_true = !psr[4] && !psr[3];
            4'd13:   cond_true = psr[4] || psr[3];
            4'd14:   cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

    assign O_PSR          = psr;
    assign O_COND_TRUE    = cond_true;
    assign O_SHADOW_VALID = shadow_valid;
    assign O_ERROR        = error;
endmodule

// File: tb/tb_cr16_psr.sv
// tb_cr16_psr: directed checks of cr16_psr flag masking, priorities,
// shadow save/restore/swap, condition decode and asynchronous reset.
module tb_cr16_psr;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0, wr = 1'b0, sv = 1'b0, rs = 1'b0;
    logic [3:0] op = 4'd0, cond = 4'd0;
    logic [4:0] st = 5'd0, wd = 5'd0;
    logic [4:0] psr;
    logic       cond_true, shadow_valid, err;
    int         vectors = 0;
    int         miscompares = 0;

    cr16_psr dut (
        .I_CLK(clk), .I_RESET(rst), .I_ENABLE(en), .I_OPCODE(op),
        .I_STATUS(st), .I_WRITE(wr), .I_WRITE_DATA(wd), .I_SAVE(sv),
        .I_RESTORE(rs), .I_COND(cond), .O_PSR(psr), .O_COND_TRUE(cond_true),
        .O_SHADOW_VALID(shadow_valid), .O_ERROR(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic e, input logic [3:0] o, input logic [4:0] s,
                       input logic w, input logic [4:0] d, input logic sa, input logic re);
        en = e; op = o; st = s; wr = w; wd = d; sv = sa; rs = re;
        @(posedge clk);
        #1;
        en = 1'b0; wr = 1'b0; sv = 1'b0; rs = 1'b0;
    endtask

    function automatic logic cond_ref(input int c, input logic [4:0] p);
        logic n, z, f, l, cy;
        {n, z, f, l, cy} = p;
        case (c)
            0: return z;        1: return !z;
            2: return cy;       3: return !cy;
            4: return l;        5: return !l;
            6: return n;        7: return !n;
            8: return f;        9: return !f;
            10: return !l && !z;
            11: return l || z;
            12: return !n && !z;
            13: return n || z;
            14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    initial begin
        #2;
        chk("reset_psr", psr, 5'b00000);
        chk("reset_sv", {4'd0, shadow_valid}, 5'd0);
        chk("reset_err", {4'd0, err}, 5'd0);
        #10 rst = 1'b0;

        cyc(1, 4'd0, 5'b11100, 0, 5'd0, 0, 0);
        chk("add_all", psr, 5'b11100);
        cond = 4'd6; #1 chk("cond_gt", {4'd0, cond_true}, 5'd1);
        cond = 4'd8; #1 chk("cond_fs", {4'd0, cond_true}, 5'd1);

        cyc(0, 4'd0, 5'd0, 1, 5'b10001, 0, 0);
        chk("write", psr, 5'b10001);
        cyc(1, 4'd6, 5'b01000, 0, 5'd0, 0, 0);
        chk("and_z_only", psr, 5'b11001);
        cyc(1, 4'd15, 5'b00000, 0, 5'd0, 0, 0);
        chk("op15_hold", psr, 5'b11001);
        cyc(0, 4'd0, 5'b11111, 0, 5'd0, 0, 0);
        chk("enable_off", psr, 5'b11001);
        cyc(0, 4'd0, 5'b11111, 1, 5'b00110, 0, 0);
        chk("write_no_en", psr, 5'b00110);
        cyc(1, 4'd13, 5'b11000, 0, 5'd0, 0, 0);
        chk("op13_z_only", psr, 5'b01110);
        cyc(1, 4'd14, 5'b11111, 0, 5'd0, 0, 0);
        chk("op14_hold", psr, 5'b01110);
        cyc(1, 4'd5, 5'b10101, 0, 5'd0, 0, 0);
        chk("op5_all", psr, 5'b10101);
        cyc(1, 4'd0, 5'b11111, 1, 5'b01010, 0, 0);
        chk("write_over_en", psr, 5'b01010);

        cyc(0, 4'd0, 5'd0, 0, 5'd0, 1, 0);
        chk("save_valid", {4'd0, shadow_valid}, 5'd1);
        chk("save_psr_kept", psr, 5'b01010);
        cyc(0, 4'd0, 5'd0, 1, 5'b10101, 0, 0);
        chk("write_after_save", psr, 5'b10101);
        cyc(1, 4'd0, 5'b11111, 1, 5'b00000, 0, 1);
        chk("restore_psr", psr, 5'b01010);
        chk("restore_sv", {4'd0, shadow_valid}, 5'd0);
        chk("restore_err", {4'd0, err}, 5'd0);
        cyc(0, 4'd0, 5'd0, 0, 5'd0, 0, 1);
        chk("bad_restore_err", {4'd0, err}, 5'd1);
        chk("bad_restore_psr", psr, 5'b01010);
        cyc(0, 4'd0, 5'd0, 0, 5'd0, 0, 0);
        chk("err_one_cycle", {4'd0, err}, 5'd0);
        cyc(0, 4'd0, 5'd0, 1, 5'b00011, 0, 1);
        chk("bad_restore_write", psr, 5'b00011);
        chk("bad_restore_write_err", {4'd0, err}, 5'd1);

        cyc(0, 4'd0, 5'd0, 0, 5'd0, 1, 0);
        cyc(0, 4'd0, 5'd0, 1, 5'b11000, 0, 0);
        cyc(0, 4'd0, 5'd0, 0, 5'd0, 1, 1);
        chk("swap_psr", psr, 5'b00011);
        chk("swap_sv", {4'd0, shadow_valid}, 5'd1);
        chk("swap_err", {4'd0, err}, 5'd0);
        cyc(0, 4'd0, 5'd0, 0, 5'd0, 0, 1);
        chk("swap_shadow", psr, 5'b11000);
        chk("swap_restore_sv", {4'd0, shadow_valid}, 5'd0);
        cyc(1, 4'd0, 5'b00101, 0, 5'd0, 1, 1);
        chk("bad_swap_psr", psr, 5'b00101);
        chk("bad_swap_err", {4'd0, err}, 5'd1);
        chk("bad_swap_sv", {4'd0, shadow_valid}, 5'd1);
        cyc(0, 4'd0, 5'd0, 0, 5'd0, 0, 1);
        chk("bad_swap_shadow", psr, 5'b11000);

        for (int v = 0; v < 32; v++) begin
            cyc(0, 4'd0, 5'd0, 1, 5'(v), 0, 0);
            for (int c = 0; c < 16; c++) begin
                cond = 4'(c);
                #1 chk($sformatf("cond_%0d_psr_%0d", c, v), {4'd0, cond_true},
                       {4'd0, cond_ref(c, 5'(v))});
            end
        end

        cyc(0, 4'd0, 5'd0, 1, 5'b11111, 1, 0);
        chk("pre_reset_psr", psr, 5'b11111);
        chk("pre_reset_sv", {4'd0, shadow_valid}, 5'd1);
        #3 rst = 1'b1;
        #1;
        chk("async_reset_psr", psr, 5'b00000);
        chk("async_reset_sv", {4'd0, shadow_valid}, 5'd0);
        #1 rst = 1'b0;
        cyc(1, 4'd2, 5'b00111, 0, 5'd0, 0, 0);
        chk("post_reset_add", psr, 5'b00111);
        cyc(0, 4'd0, 5'd0, 0, 5'd0, 0, 1);
        chk("post_reset_shadow_invalid", {4'd0, err}, 5'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish, required finish");
        $fatal(1);
    end
endmodule

// File: doc/cr16_psr.md
# cr16_psr

Processor status register and branch-condition evaluator for the CR16 datapath, directly downstream of `cr16_alu`. It captures the ALU's 5-bit `O_STATUS` into the architectural PSR flags, using a per-opcode update mask. It also holds a one-deep shadow copy for interrupt entry and exit, and evaluates the 4-bit CR16 condition code used by Bcond/Jcond/Scond. The control unit drives it one cycle behind the ALU result.

## Interface
Parameters:
- `RESET_PSR`, 5'b00000: value loaded into the PSR and the shadow on reset.

Ports:
- `I_CLK` input 1: system clock; all state updates on the rising edge.
- `I_RESET` input 1: asynchronous, active-high reset.
- `I_ENABLE` input 1: ALU result valid this cycle; qualifies the flag update.
- `I_OPCODE` input 4: ALU opcode that produced `I_STATUS`.
- `I_STATUS` input 5: ALU flags. Bit 0 = C (carry), bit 1 = L (low), bit 2 = F (flag/overflow), bit 3 = Z (zero), bit 4 = N (negative).
- `I_WRITE` input 1: direct PSR load (LPR).
- `I_WRITE_DATA` input 5: value for the direct load.
- `I_SAVE` input 1: copy the PSR into the shadow (interrupt entry).
- `I_RESTORE` input 1: copy the shadow into the PSR (RETX).
- `I_COND` input 4: condition code to evaluate.
- `O_PSR` output 5: current PSR, same bit layout as `I_STATUS`.
- `O_COND_TRUE` output 1: result of evaluating `I_COND` against `O_PSR`.
- `O_SHADOW_VALID` output 1: the shadow holds an unrestored save.
- `O_ERROR` output 1: one-cycle pulse on a restore while the shadow is invalid.

## Operation
- Reset (asynchronous): `O_PSR` = `RESET_PSR`, shadow = `RESET_PSR`, `O_SHADOW_VALID` = 0, `O_ERROR` = 0.
- Flag update mask, applied only when `I_ENABLE` = 1:
  - Opcodes 0–5 (ADD, ADDU, ADDC, ADDCU, SUB, SUBU): all five bits load from `I_STATUS`.
  - Opcodes 6–13 (logic and shifts): only Z loads from `I_STATUS[3]`; C, L, F and N hold.
  - Opcodes 14–15: no change.
- Next-PSR priority, highest first:
  - `I_RESTORE` with a valid shadow: PSR = shadow.
  - `I_WRITE`: PSR = `I_WRITE_DATA`.
  - `I_ENABLE`: PSR is updated through the mask above.
  - Otherwise the PSR holds.
- A restore with an invalid shadow does nothing to the PSR. It pulses `O_ERROR`, and the lower-priority sources (write, enable) still apply in that cycle.
- `I_SAVE`: shadow = the pre-edge PSR and `O_SHADOW_VALID` = 1, regardless of any concurrent PSR update.
- `I_RESTORE` with a valid shadow clears `O_SHADOW_VALID`.
- `I_SAVE` and `I_RESTORE` in the same cycle perform a swap: the PSR gets the old shadow, the shadow gets the old PSR, and `O_SHADOW_VALID` ends at 1. If the shadow was invalid, the restore half is an error (`O_ERROR` pulses, PSR follows write/enable) and the save half still occurs.
- Condition decode (combinational from `O_PSR`):
  - 0 EQ: Z = 1
  - 1 NE: Z = 0
  - 2 CS: C = 1
  - 3 CC: C = 0
  - 4 HI: L = 1
  - 5 LS: L = 0
  - 6 GT: N = 1
  - 7 LE: N = 0
  - 8 FS: F = 1
  - 9 FC: F = 0
  - 10 LO: L = 0 and Z = 0
  - 11 HS: L = 1 or Z = 1
  - 12 LT: N = 0 and Z = 0
  - 13 GE: N = 1 or Z = 1
  - 14 UC: always 1
  - 15: always 0

## Timing
- Every PSR source becomes visible on `O_PSR` at the first rising edge after it is sampled (1-cycle latency).
- There is no bypass path. A branch issued in the same cycle as the flag-setting ALU op evaluates the old PSR; the control unit inserts the one-cycle spacing.
- `O_COND_TRUE` is purely combinational from the registered `O_PSR` and `I_COND`, and is valid in the same cycle `I_COND` changes.
- `O_ERROR` is registered: it is high for exactly the one cycle after the offending edge.
- Reset asserted mid-operation clears all state immediately. It does not wait for a clock edge.
- The first edge after reset deasserts behaves normally.

## Test plan
- Reset, then ADD (opcode 0) with `I_STATUS` = 5'b11100 and `I_ENABLE` = 1 → next cycle `O_PSR` = 5'b11100. With `I_COND` = 6, `O_COND_TRUE` = 1; with `I_COND` = 8, `O_COND_TRUE` = 1.
- PSR = 5'b10001, then AND (opcode 6) with `I_STATUS` = 5'b01000 → `O_PSR` = 5'b11001. Then opcode 15 with `I_STATUS` = 5'b00000 → `O_PSR` stays 5'b11001.
- `I_ENABLE` = 0 with opcode 0 and `I_STATUS` = 5'b11111 → PSR unchanged. Same cycle with `I_WRITE` = 1 and data 5'b00110 → `O_PSR` = 5'b00110.
- PSR = 5'b01010, pulse `I_SAVE` → `O_SHADOW_VALID` = 1. Write 5'b10101, then pulse `I_RESTORE` → `O_PSR` = 5'b01010 and `O_SHADOW_VALID` = 0. A second restore → `O_ERROR` pulses once and PSR is unchanged.
- Sweep `I_COND` 0–15 for each of 32 PSR values, checking `O_COND_TRUE` against the decode list.
- Assert `I_RESET` between clock edges while PSR = 5'b11111 and the shadow is valid → `O_PSR` = 0 and `O_SHADOW_VALID` = 0 immediately, before the next edge.
